// File: rtl/video_pipe_proc.sv
// Video pixel pipeline: per-frame selectable colour processing with fixed latency,
// plus active-area measurement (width/height/consistency) and a frame counter.
module video_pipe_proc #(
  parameter int DATA_W = 8,
  parameter int DELAY  = 2,
  parameter int CNT_W  = 12
) (
  input  logic              hdmi_clk,
  input  logic              hdmi_rst_n,
  input  logic              in_de,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        mode_req,
  output logic              out_de,
  output logic              out_hs,
  output logic              out_vs,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic [CNT_W-1:0]  meas_width,
  output logic [CNT_W-1:0]  meas_height,
  output logic              meas_valid,
  output logic [15:0]       frame_cnt
);

  // (r + 2g + b) / 4 fits back in DATA_W bits; the extra two bits only hold the sum.
  function automatic logic [DATA_W-1:0] gray_f(input logic [DATA_W-1:0] r,
                                               input logic [DATA_W-1:0] g,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[DATA_W+1:2];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              vs_d;
  logic              de_d;
  logic              vs_rise;
  logic              de_fall;
  logic [1:0]        mode_act;
  logic [1:0]        mode_eff;
  logic [DATA_W-1:0] gray;
  logic [DATA_W-1:0] r_p0, g_p0, b_p0;

  logic [2:0]          ctl_p [DELAY];
  logic [3*DATA_W-1:0] pix_p [DELAY];

  assign vs_rise  = in_vs & ~vs_d;
  assign de_fall  = de_d & ~in_de;
  // A mode loaded on vs_rise already applies to the pixel sampled in that cycle.
  assign mode_eff = vs_rise ? mode_req : mode_act;
  assign gray     = gray_f(in_r, in_g, in_b);

  // Stage p0: colour processing; blanked samples carry zero data down the pipe.
  always_comb begin
    r_p0 = '0;
    g_p0 = '0;
    b_p0 = '0;
    if (in_de) begin
      case (mode_eff)
        2'd0: begin r_p0 = in_r; g_p0 = in_g; b_p0 = in_b; end
        2'd1: begin r_p0 = gray; g_p0 = gray; b_p0 = gray; end
        2'd2: begin r_p0 = in_b; g_p0 = in_g; b_p0 = in_r; end
        default: begin r_p0 = '0; g_p0 = '0; b_p0 = '0; end
      endcase
    end
  end

  // Stages p[0..DELAY-1]: control and pixel travel together.
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        ctl_p[i] <= '0;
        pix_p[i] <= '0;
      end
    end else begin
      ctl_p[0] <= {in_de, in_hs, in_vs};
      pix_p[0] <= {r_p0, g_p0, b_p0};
      for (int i = 1; i < DELAY; i++) begin
        ctl_p[i] <= ctl_p[i-1];
        pix_p[i] <= pix_p[i-1];
      end
    end
  end

  assign {out_de, out_hs, out_vs} = ctl_p[DELAY-1];
  assign {out_r, out_g, out_b}    = pix_p[DELAY-1];

  logic [CNT_W-1:0] pix_cnt, line_cnt, ref_w;
  logic [CNT_W-1:0] line_nx, ref_nx;
  logic             mismatch, mis_nx, first_seen;

  // Line state including a line that ends in this very cycle.
  always_comb begin
    line_nx = line_cnt;
    ref_nx  = ref_w;
    mis_nx  = mismatch;
    if (de_fall) begin
      line_nx = sat_inc(line_cnt);
      if (line_cnt == '0)
        ref_nx = pix_cnt;
      else if (pix_cnt != ref_w)
        mis_nx = 1'b1;
    end
  end

  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      mode_act    <= 2'd0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      ref_w       <= '0;
      mismatch    <= 1'b0;
      first_seen  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      meas_valid  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vs_d <= in_vs;
      de_d <= in_de;
      if (in_de)
        pix_cnt <= sat_inc(pix_cnt);
      else if (de_fall)
        pix_cnt <= '0;
      if (vs_rise) begin
        mode_act   <= mode_req;
        frame_cnt  <= frame_cnt + 16'd1;
        first_seen <= 1'b1;
        // The first frame after reset is partial, so it is never reported.
        if (first_seen) begin
          meas_width  <= ref_nx;
          meas_height <= line_nx;
          meas_valid  <= (line_nx != '0) && !mis_nx;
        end
        line_cnt <= '0;
        ref_w    <= '0;
        mismatch <= 1'b0;
      end else begin
        line_cnt <= line_nx;
        ref_w    <= ref_nx;
        mismatch <= mis_nx;
      end
    end
  end

endmodule

// File: tb/tb_video_pipe_proc.sv
// Directed bench for video_pipe_proc: vector table for the pixel path and
// hand-written frame sequences for measurement and reset behaviour.
module tb_video_pipe_proc;

  logic        hdmi_clk = 1'b0;
  logic        hdmi_rst_n;
  logic        in_de, in_hs, in_vs;
  logic [7:0]  in_r, in_g, in_b;
  logic [1:0]  mode_req;
  logic        out_de, out_hs, out_vs;
  logic [7:0]  out_r, out_g, out_b;
  logic [11:0] meas_width, meas_height;
  logic        meas_valid;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  video_pipe_proc #(.DATA_W(8), .DELAY(2), .CNT_W(12)) dut (
    .hdmi_clk   (hdmi_clk),
    .hdmi_rst_n (hdmi_rst_n),
    .in_de      (in_de),
    .in_hs      (in_hs),
    .in_vs      (in_vs),
    .in_r       (in_r),
    .in_g       (in_g),
    .in_b       (in_b),
    .mode_req   (mode_req),
    .out_de     (out_de),
    .out_hs     (out_hs),
    .out_vs     (out_vs),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .meas_width (meas_width),
    .meas_height(meas_height),
    .meas_valid (meas_valid),
    .frame_cnt  (frame_cnt)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  typedef struct {
    logic       de, hs, vs;
    logic [7:0] r, g, b;
    logic [1:0] mode;
    logic       ede, ehs, evs;
    logic [7:0] er, eg, eb;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic de, input logic hs, input logic vs);
    in_de = de;
    in_hs = hs;
    in_vs = vs;
    @(posedge hdmi_clk);
    #1;
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] pix_out();
    return 64'({out_de, out_hs, out_vs, out_r, out_g, out_b});
  endfunction

  function automatic logic [63:0] meas_out();
    return 64'({meas_width, meas_height, meas_valid});
  endfunction

  initial begin
    //        de    hs    vs    r      g      b      mode   ede   ehs   evs   er     eg     eb
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 2'd2, 1'b1, 1'b0, 1'b1, 8'h20, 8'h20, 8'h20};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 2'd2, 1'b1, 1'b0, 1'b0, 8'h02, 8'h02, 8'h02};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h04, 8'h05, 8'h06, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h07, 8'h08, 8'h09, 2'd3, 1'b1, 1'b0, 1'b1, 8'h03, 8'h02, 8'h01};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'hAA, 8'hBB, 8'hCC, 2'd3, 1'b1, 1'b0, 1'b1, 8'h06, 8'h05, 8'h04};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC, 2'd3, 1'b1, 1'b0, 1'b0, 8'h09, 8'h08, 8'h07};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};

    // Reset held with live input: everything must stay cleared.
    hdmi_rst_n = 1'b0;
    in_r = 8'h12; in_g = 8'h34; in_b = 8'h56; mode_req = 2'd2;
    repeat (3) step(1'b1, 1'b1, 1'b1);
    check("reset_pix", pix_out(), 64'h0);
    check("reset_meas", 64'({meas_out(), frame_cnt}), 64'h0);

    hdmi_rst_n = 1'b1;
    in_r = 8'h00; in_g = 8'h00; in_b = 8'h00; mode_req = 2'd0;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Pixel path vectors: each row's expectation is the output of the row two earlier.
    for (int i = 0; i < 15; i++) begin
      in_r = tbl[i].r; in_g = tbl[i].g; in_b = tbl[i].b; mode_req = tbl[i].mode;
      in_de = tbl[i].de; in_hs = tbl[i].hs; in_vs = tbl[i].vs;
      check($sformatf("vec%0d", i), pix_out(),
            64'({tbl[i].ede, tbl[i].ehs, tbl[i].evs, tbl[i].er, tbl[i].eg, tbl[i].eb}));
      @(posedge hdmi_clk);
      #1;
    end
    check("vec_frame_cnt", 64'(frame_cnt), 64'd3);
    check("vec_meas", meas_out(), 64'({12'd3, 12'd1, 1'b1}));

    // Mid-line asynchronous reset, then empty-pipeline restart in mode 0.
    in_r = 8'h12; in_g = 8'h34; in_b = 8'h56; mode_req = 2'd0;
    repeat (4) step(1'b1, 1'b0, 1'b0);
    hdmi_rst_n = 1'b0;
    #1;
    check("async_rst_pix", pix_out(), 64'h0);
    check("async_rst_meas", 64'({meas_out(), frame_cnt}), 64'h0);
    @(posedge hdmi_clk);
    #1;
    hdmi_rst_n = 1'b1;
    check("post_rst_c0", pix_out(), 64'h0);
    step(1'b1, 1'b0, 1'b0);
    check("post_rst_c1", pix_out(), 64'h0);
    step(1'b1, 1'b0, 1'b0);
    check("post_rst_c2", pix_out(), 64'({1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56}));
    line(3);
    line(640);
    line(640);
    vs_pulse();
    check("partial_meas", meas_out(), 64'h0);
    check("partial_fcnt", 64'(frame_cnt), 64'd1);
    repeat (4) line(640);
    vs_pulse();
    check("full_meas", meas_out(), 64'({12'd640, 12'd4, 1'b1}));
    check("full_fcnt", 64'(frame_cnt), 64'd2);

    // Three consistent frames from a fresh reset.
    hdmi_rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    hdmi_rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    vs_pulse();
    repeat (4) line(640);
    vs_pulse();
    repeat (4) line(640);
    vs_pulse();
    check("three_meas", meas_out(), 64'({12'd640, 12'd4, 1'b1}));
    check("three_fcnt", 64'(frame_cnt), 64'd3);

    // Third line one pixel short.
    line(640);
    line(640);
    line(639);
    line(640);
    vs_pulse();
    check("short_meas", meas_out(), 64'({12'd640, 12'd4, 1'b0}));
    check("short_fcnt", 64'(frame_cnt), 64'd4);

    // Last line ends in the same cycle as vs_rise.
    repeat (3) line(640);
    repeat (640) step(1'b1, 1'b0, 1'b0);
    vs_pulse();
    check("edge_meas", meas_out(), 64'({12'd640, 12'd4, 1'b1}));
    check("edge_fcnt", 64'(frame_cnt), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_pipe_proc.md
VIDEO_PIPE_PROC -- requirements
Module: video_pipe_proc

Interface
REQ-001 SHALL have parameter: DATA_W, 8, bits per colour channel (4..12).
REQ-002 SHALL have parameter: DELAY, 2, input-to-output latency in hdmi_clk cycles (1..16).
REQ-003 SHALL have parameter: CNT_W, 12, width of the resolution counters.
REQ-004 SHALL have port: hdmi_clk  in  1  pixel clock; sole clock domain.
REQ-005 SHALL have port: hdmi_rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: in_de, in_hs, in_vs  in  1 each  input data-enable and syncs (active-high).
REQ-007 SHALL have ports: in_r, in_g, in_b  in  DATA_W each  input pixel.
REQ-008 SHALL have port: mode_req  in  2  requested mode: 0 pass, 1 gray, 2 RGB->BGR swap, 3 blank.
REQ-009 SHALL have ports: out_de, out_hs, out_vs  out  1 each  delayed control.
REQ-010 SHALL have ports: out_r, out_g, out_b  out  DATA_W each  processed pixel.
REQ-011 SHALL have ports: meas_width, meas_height  out  CNT_W each  measured active size of the last complete frame.
REQ-012 SHALL have port: meas_valid  out  1  last measurement was complete and consistent.
REQ-013 SHALL have port: frame_cnt  out  16  count of in_vs rising edges.

Function
REQ-014 SHALL present out_de/out_hs/out_vs as in_de/in_hs/in_vs delayed exactly DELAY cycles.
REQ-015 SHALL present out_r/g/b for an input pixel in the same cycle as that pixel's out_de, i.e. also exactly DELAY cycles later.
REQ-016 SHALL define vs_rise as in_vs=1 while the registered in_vs of the previous cycle was 0.
REQ-017 SHALL hold an active mode register, loading mode_req only on a vs_rise cycle; the pixel sampled in that cycle is processed with the new mode.
REQ-018 SHALL ignore mode_req changes between vs_rise events.
REQ-019 Mode 0: SHALL output r,g,b unchanged.
REQ-020 Mode 1: SHALL compute y = (r + 2g + b) >> 2 at DATA_W+2 bits with no overflow or rounding, and output r=g=b=y.
REQ-021 Mode 2: SHALL output out_r=b, out_g=g, out_b=r.
REQ-022 Mode 3: SHALL output zero data, with syncs and de still delayed normally.
REQ-023 SHALL force out_r/g/b to 0 whenever the delayed de is 0, in every mode.
REQ-024 SHALL maintain a pixel counter that increments on every cycle with in_de=1 and saturates at 2^CNT_W-1.
REQ-025 On each in_de falling edge (registered de=1, in_de=0): SHALL record the pixel count as the line width, increment the line counter (saturating), and clear the pixel counter.
REQ-026 SHALL latch the first line width of each frame as the reference width, and set a mismatch flag if any later line in that frame has a different width.
REQ-027 On vs_rise after at least one earlier vs_rise since reset: SHALL load meas_width with the reference width, meas_height with the line count, and meas_valid with (line count > 0 AND no mismatch); then SHALL clear the line counter, mismatch flag and reference width.
REQ-028 On the first vs_rise after reset (partial frame): SHALL clear the line state but leave meas_* unchanged.
REQ-029 When a de falling edge and vs_rise occur in the same cycle, SHALL count that line in the closing frame before capture.
REQ-030 SHALL increment frame_cnt on every vs_rise, wrapping from 0xFFFF to 0.

Reset
REQ-031 SHALL, while hdmi_rst_n=0, asynchronously clear every output, the delay pipeline, all counters and flags, and the first-vs flag, and set the active mode to 0.
REQ-032 SHALL resume with the pipeline empty after reset release: outputs stay 0 for DELAY cycles regardless of input.

Verification
REQ-033 Reset then stream with DELAY=2, mode_req=0 -> pixel (0x12,0x34,0x56) with in_de=1 at cycle t appears on out_r/g/b with out_de=1 at t+2; hs/vs are aligned identically.
REQ-034 mode_req=1 set before vs_rise, pixel (0x10,0x20,0x30) -> out=(0x20,0x20,0x20); pixel (0xFF,0xFF,0xFF) -> out=(0xFF,0xFF,0xFF).
REQ-035 mode_req changed 0->2 mid-frame -> output stays pass-through until the next vs_rise; from the vs_rise pixel onward, (1,2,3) -> (3,2,1).
REQ-036 Three frames of 640 px x 4 lines -> after the 3rd vs_rise: meas_width=640, meas_height=4, meas_valid=1, frame_cnt=3.
REQ-037 Frame where line 3 is 639 px -> meas_valid=0 at the next vs_rise; meas_height=4.
REQ-038 Assert hdmi_rst_n low mid-line, release, then run a partial frame and one full frame -> all outputs 0 during reset; meas_* remain 0 after the first vs_rise; valid measurement after the second vs_rise.
